reg_scoreboard: RTL and testbench

Register scoreboard for the 5-stage pipeline: the writer-side complement to the hazard detector. It records destination registers as instructions issue from decode, retires them at writeback, and squashes them on flush. From that record it produces the decode-stage RAW stall. Per-register up/down counters replace the three parallel stage comparisons, so stall generation no longer depends on the pipeline depth.

---
 rtl/reg_scoreboard_pkg.sv | 11 +
 rtl/reg_scoreboard_if.sv | 35 +++
 rtl/reg_scoreboard_sb_counter.sv | 34 +++
 rtl/reg_scoreboard.sv | 62 ++++++
 tb/tb_reg_scoreboard.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing for the register scoreboard: register file geometry and
// pending-write counter width.
package reg_scoreboard_pkg;
    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/flush bus into the scoreboard and the stall/status
// signals it returns to decode.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic                issue_valid;
    logic                issue_wr_en;
    reg_idx_t            issue_wr_reg;
    reg_idx_t            issue_rd1;
    reg_idx_t            issue_rd2;
    logic                issue_rd1_used;
    logic                issue_rd2_used;
    logic                wb_valid;
    reg_idx_t            wb_reg;
    logic                squash_valid;
    reg_idx_t            squash_reg;
    logic                stall;
    logic                issue_fire;
    logic [NUM_REGS-1:0] busy;
    logic                err_underflow;

    modport master (
        output issue_valid, issue_wr_en, issue_wr_reg,
        output issue_rd1, issue_rd2, issue_rd1_used, issue_rd2_used,
        output wb_valid, wb_reg, squash_valid, squash_reg,
        input  stall, issue_fire, busy, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wr_en, issue_wr_reg,
        input  issue_rd1, issue_rd2, issue_rd1_used, issue_rd2_used,
        input  wb_valid, wb_reg, squash_valid, squash_reg,
        output stall, issue_fire, busy, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Pending-write counter for one register: +inc, -dec (0..2) in one step,
// clamping at zero and flagging the cycle in which it would have gone negative.
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic [1:0] i_dec,
    output cnt_t       o_count,
    output logic       o_uf
);
    localparam int SW = (CNT_W > 1) ? CNT_W + 1 : 2;

    cnt_t          r_count;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_dec;
    logic [SW-1:0] w_diff;

    // Net result of inc and dec computed in one wider add so there is no
    // transient through zero when both happen together.
    assign w_sum  = SW'(r_count) + SW'(i_inc);
    assign w_dec  = SW'(i_dec);
    assign w_diff = w_sum - w_dec;
    assign o_uf   = (w_dec > w_sum);

    always_ff @(posedge clk) begin
        if (!rst_n)    r_count <= '0;
        else if (o_uf) r_count <= '0;
        else           r_count <= w_diff[CNT_W-1:0];
    end

    assign o_count = r_count;
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters driving the
// decode-stage RAW stall, with a writeback bypass and a sticky underflow flag.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    reg_scoreboard_if.slave sb
);
    cnt_t [NUM_REGS-1:0] w_count;
    logic [NUM_REGS-1:0] w_uf;
    logic [NUM_REGS-1:0] w_pend;
    logic [NUM_REGS-1:0] w_busy;
    logic                w_hazard1;
    logic                w_hazard2;
    logic                w_full;
    logic                w_stall;
    logic                w_fire;
    logic                r_err;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic       w_inc;
        logic       w_wb_hit;
        logic       w_sq_hit;
        logic [1:0] w_dec;

        assign w_wb_hit = sb.wb_valid & (sb.wb_reg == REG_W'(i));
        assign w_sq_hit = sb.squash_valid & (sb.squash_reg == REG_W'(i));
        assign w_inc    = w_fire & sb.issue_wr_en & (sb.issue_wr_reg == REG_W'(i));
        assign w_dec    = {1'b0, w_wb_hit} + {1'b0, w_sq_hit};

        sb_counter u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_inc   (w_inc),
            .i_dec   (w_dec),
            .o_count (w_count[i]),
            .o_uf    (w_uf[i])
        );

        assign w_busy[i] = (w_count[i] != '0);
        // Last outstanding write retiring now: the regfile write-before-read
        // hands the value to decode, so the reader need not wait.
        assign w_pend[i] = w_busy[i] & ~((w_count[i] == cnt_t'(1)) & w_wb_hit);
    end

    assign w_hazard1 = sb.issue_rd1_used & w_pend[sb.issue_rd1];
    assign w_hazard2 = sb.issue_rd2_used & w_pend[sb.issue_rd2];
    assign w_full    = sb.issue_wr_en & (w_count[sb.issue_wr_reg] == cnt_t'(CNT_MAX));
    assign w_stall   = sb.issue_valid & (w_hazard1 | w_hazard2 | w_full);
    assign w_fire    = sb.issue_valid & ~w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= r_err | (|w_uf);
    end

    assign sb.stall         = w_stall;
    assign sb.issue_fire    = w_fire;
    assign sb.busy          = w_busy;
    assign sb.err_underflow = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench: the driver queues hand-computed expectations per cycle and
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        string      nm;
        logic       st;
        logic       fi;
        logic [7:0] bz;
        logic       er;
    } exp_t;

    exp_t exp_q[$];

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void cmp(string nm, string fld, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, fld, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.nm, "stall", 8'(sb_if.stall), 8'(e.st));
            cmp(e.nm, "fire",  8'(sb_if.issue_fire), 8'(e.fi));
            cmp(e.nm, "busy",  sb_if.busy, e.bz);
            cmp(e.nm, "err",   8'(sb_if.err_underflow), 8'(e.er));
        end
    end

    task automatic drive(input logic iv, input logic we, input int wr,
                         input int r1, input logic u1, input int r2, input logic u2,
                         input logic wbv, input int wbr, input logic sqv, input int sqr);
        sb_if.issue_valid    = iv;
        sb_if.issue_wr_en    = we;
        sb_if.issue_wr_reg   = REG_W'(wr);
        sb_if.issue_rd1      = REG_W'(r1);
        sb_if.issue_rd1_used = u1;
        sb_if.issue_rd2      = REG_W'(r2);
        sb_if.issue_rd2_used = u2;
        sb_if.wb_valid       = wbv;
        sb_if.wb_reg         = REG_W'(wbr);
        sb_if.squash_valid   = sqv;
        sb_if.squash_reg     = REG_W'(sqr);
    endtask

    // Present inputs for one cycle, queue the expected outputs, advance.
    task automatic step(input string nm, input logic st, input logic fi,
                        input logic [7:0] bz, input logic er);
        exp_t e;
        e.nm = nm; e.st = st; e.fi = fi; e.bz = bz; e.er = er;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        // Reset held two cycles under random inputs.
        for (int k = 0; k < 2; k++) begin
            drive($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,7),
                  $urandom_range(0,7), $urandom_range(0,1), $urandom_range(0,7),
                  $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,7),
                  $urandom_range(0,1), $urandom_range(0,7));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle();                                 step("rst_idle", 0, 0, 8'h00, 0);
        drive(1, 0, 0, 3, 1, 5, 1, 0, 0, 0, 0); step("rst_rd",   0, 1, 8'h00, 0);

        // Back-to-back RAW on R3, released by same-cycle writeback.
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); step("raw_wr",   0, 1, 8'h00, 0);
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0); step("raw_st",   1, 0, 8'h08, 0);
        drive(1, 0, 0, 3, 1, 0, 0, 1, 3, 0, 0); step("raw_byp",  0, 1, 8'h08, 0);
        idle();                                 step("raw_clr",  0, 0, 8'h00, 0);

        // Unused source on a busy register.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0); step("un_wr",    0, 1, 8'h00, 0);
        drive(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0); step("un_rd2",   0, 1, 8'h20, 0);
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); step("used_rd2", 1, 0, 8'h20, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0); step("un_wb",    0, 0, 8'h20, 0);

        // Saturation on R2.
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0); step("sat_w1",   0, 1, 8'h00, 0);
        step("sat_w2", 0, 1, 8'h04, 0);
        step("sat_w3", 0, 1, 8'h04, 0);
        step("sat_full", 1, 0, 8'h04, 0);
        drive(1, 1, 2, 0, 0, 0, 0, 1, 2, 0, 0); step("sat_wb",   1, 0, 8'h04, 0);
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0); step("sat_w4",   0, 1, 8'h04, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0); step("sat_d1",   0, 0, 8'h04, 0);
        step("sat_d2", 0, 0, 8'h04, 0);
        step("sat_d3", 0, 0, 8'h04, 0);
        idle();                                 step("sat_clr",  0, 0, 8'h00, 0);

        // Issue + wb + squash on R4 together, then a lone squash underflows.
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0); step("sim_wr",   0, 1, 8'h00, 0);
        drive(1, 1, 4, 0, 0, 0, 0, 1, 4, 1, 4); step("sim_all",  0, 1, 8'h10, 0);
        idle();                                 step("sim_net",  0, 0, 8'h00, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4); step("uf_sq",    0, 0, 8'h00, 0);
        idle();                                 step("uf_err",   0, 0, 8'h00, 1);

        // Mid-operation reset with R2/R3/R5 pending.
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0); step("mr_w2",    0, 1, 8'h00, 1);
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); step("mr_w3",    0, 1, 8'h04, 1);
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0); step("mr_w5",    0, 1, 8'h0C, 1);
        drive(0, 0, 0, 2, 1, 3, 1, 0, 0, 0, 0); step("mr_noiv",  0, 0, 8'h2C, 1);
        rst_n = 1'b0;
        idle();                                 step("mr_rst",   0, 0, 8'h2C, 1);
        rst_n = 1'b1;
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0); step("mr_rd",    0, 1, 8'h00, 0);
        idle();                                 step("mr_end",   0, 0, 8'h00, 0);

        // Let the monitor drain, bounded.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
